// File: rtl/cnn_mul_share_arbiter.sv
// Round-robin share of one pipelined signed multiplier among N_REQ requesters.
// Latency: LAT cycles from accept to result register; each stall cycle adds one.
// Backpressure: whole pipe freezes while res_valid & !res_ready; no grants then.
module cnn_mul_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DIN0_W = 14,
    parameter int DIN1_W = 12,
    parameter int DOUT_W = 26,
    parameter int LAT    = 2,
    parameter int ID_W   = 2
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DIN0_W-1:0]  req_din0,
    input  logic [N_REQ*DIN1_W-1:0]  req_din1,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic [DOUT_W-1:0]        res_dout,
    output logic                     busy
);

    // operand 1 is split into a signed high part and an unsigned low part
    localparam int LO_W = DIN1_W / 2;
    localparam int HI_W = DIN1_W - LO_W;
    localparam int PL_W = DIN0_W + LO_W + 1;
    localparam int PH_W = DIN0_W + HI_W;

    logic                   advance;
    logic                   found;
    logic [ID_W-1:0]        gnt_idx;
    logic [ID_W-1:0]        rr;
    logic [ID_W-1:0]        rr_nxt;
    logic [DIN0_W-1:0]      sel_din0;
    logic [DIN1_W-1:0]      sel_din1;
    logic [LAT-1:0]         s_vld;
    logic [ID_W-1:0]        s_id [LAT];

    logic signed [PL_W-1:0] pl_a, pl_b, pl_nxt;
    logic signed [PH_W-1:0] ph_a, ph_b, ph_nxt;

    assign res_valid = s_vld[LAT-1];
    assign res_id    = s_id[LAT-1];
    assign busy      = |s_vld;
    assign advance   = !res_valid || res_ready;

    always_comb begin
        int idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (ap_rst_n && advance && found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign rr_nxt   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign sel_din0 = req_din0[gnt_idx*DIN0_W +: DIN0_W];
    assign sel_din1 = req_din1[gnt_idx*DIN1_W +: DIN1_W];

    assign pl_a   = PL_W'($signed(sel_din0));
    assign pl_b   = PL_W'($signed({1'b0, sel_din1[LO_W-1:0]}));
    assign ph_a   = PH_W'($signed(sel_din0));
    assign ph_b   = PH_W'($signed(sel_din1[DIN1_W-1:LO_W]));
    assign pl_nxt = pl_a * pl_b;
    assign ph_nxt = ph_a * ph_b;

    function automatic logic [DOUT_W-1:0] combine(input logic signed [PL_W-1:0] pl,
                                                   input logic signed [PH_W-1:0] ph);
        combine = {ph, {LO_W{1'b0}}} + DOUT_W'(pl);
    endfunction

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s_vld <= '0;
            rr    <= '0;
            for (int k = 0; k < LAT; k++) begin
                s_id[k] <= '0;
            end
        end else if (advance) begin
            s_vld[0] <= found;
            s_id[0]  <= gnt_idx;
            for (int k = 1; k < LAT; k++) begin
                s_vld[k] <= s_vld[k-1];
                s_id[k]  <= s_id[k-1];
            end
            if (found) begin
                rr <= rr_nxt;
            end
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            logic [DOUT_W-1:0] dq;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    dq <= '0;
                end else if (advance) begin
                    dq <= combine(pl_nxt, ph_nxt);
                end
            end

            assign res_dout = dq;
        end else begin : g_latn
            // partial products in S1, summed into S2, then plain delay stages
            logic signed [PL_W-1:0] s1_pl;
            logic signed [PH_W-1:0] s1_ph;
            logic [DOUT_W-1:0]      dq [LAT-1];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    s1_pl <= '0;
                    s1_ph <= '0;
                    for (int k = 0; k < LAT - 1; k++) begin
                        dq[k] <= '0;
                    end
                end else if (advance) begin
                    s1_pl <= pl_nxt;
                    s1_ph <= ph_nxt;
                    dq[0] <= combine(s1_pl, s1_ph);
                    for (int k = 1; k < LAT - 1; k++) begin
                        dq[k] <= dq[k-1];
                    end
                end
            end

            assign res_dout = dq[LAT-2];
        end
    endgenerate

endmodule

// File: tb/tb_cnn_mul_share_arbiter.sv
// Bench for cnn_mul_share_arbiter: directed vector table, corner sequences and
// random traffic, all checked cycle by cycle against a slot-level model.
module tb_cnn_mul_share_arbiter;
    localparam int N   = 4;
    localparam int W0  = 14;
    localparam int W1  = 12;
    localparam int WO  = 26;
    localparam int LAT = 2;
    localparam int IDW = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W0-1:0]   req_din0;
    logic [N*W1-1:0]   req_din1;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [WO-1:0]     res_dout;
    logic              busy;

    always #5 ap_clk = ~ap_clk;

    cnn_mul_share_arbiter #(
        .N_REQ(N), .DIN0_W(W0), .DIN1_W(W1), .DOUT_W(WO), .LAT(LAT), .ID_W(IDW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_dout(res_dout), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: LAT slots, each {valid, id, product}; rr as a plain integer
    bit     m_vld [LAT];
    int     m_id  [LAT];
    longint m_dat [LAT];
    int     m_rr;
    int     acc_cnt, con_cnt, stepn;
    int     glog [$];
    longint rlog [$];
    int     rstep [$];

    logic [N-1:0]  obs_rdy;
    logic          obs_vld;
    logic [IDW-1:0] obs_id;
    logic [WO-1:0] obs_dout;

    task automatic model_reset();
        for (int k = 0; k < LAT; k++) begin
            m_vld[k] = 1'b0;
            m_id[k]  = 0;
            m_dat[k] = 0;
        end
        m_rr    = 0;
        acc_cnt = 0;
        con_cnt = 0;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_din0[i*W0 +: W0] = W0'(a);
        req_din1[i*W1 +: W1] = W1'(b);
    endtask

    // called just after a falling edge with inputs already driven
    task automatic step();
        bit           adv;
        bit           eb;
        int           g;
        int           d0, d1;
        logic [N-1:0] er;
        logic [WO-1:0] ed;
        #1;
        adv = !m_vld[LAT-1] || res_ready;
        g   = -1;
        if (adv) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        eb = 1'b0;
        for (int k = 0; k < LAT; k++) if (m_vld[k]) eb = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("res_valid", 64'(res_valid), 64'(m_vld[LAT-1]));
        chk("busy", 64'(busy), 64'(eb));
        if (m_vld[LAT-1]) begin
            ed = m_dat[LAT-1][WO-1:0];
            chk("res_id", 64'(res_id), 64'(m_id[LAT-1]));
            chk("res_dout", 64'(res_dout), 64'(ed));
        end
        obs_rdy  = req_ready;
        obs_vld  = res_valid;
        obs_id   = res_id;
        obs_dout = res_dout;
        if (m_vld[LAT-1] && res_ready) begin
            con_cnt++;
            rlog.push_back(m_dat[LAT-1]);
            rstep.push_back(stepn);
        end
        if (adv) begin
            for (int k = LAT - 1; k > 0; k--) begin
                m_vld[k] = m_vld[k-1];
                m_id[k]  = m_id[k-1];
                m_dat[k] = m_dat[k-1];
            end
            m_vld[0] = (g >= 0);
            if (g >= 0) begin
                d0 = $signed(req_din0[g*W0 +: W0]);
                d1 = $signed(req_din1[g*W1 +: W1]);
                m_id[0]  = g;
                m_dat[0] = longint'(d0) * longint'(d1);
                m_rr     = (g + 1) % N;
                glog.push_back(g);
                acc_cnt++;
            end
        end
        stepn++;
        @(negedge ap_clk);
    endtask

    typedef struct {
        int            id;
        int            d0;
        int            d1;
        logic [WO-1:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int  got, seen, lat, opn, first3;
        bit  alt_ok;

        vt[0] = '{2, -3, 5, WO'(-15)};
        vt[1] = '{0, -8192, -2048, WO'(16777216)};
        vt[2] = '{1, 8191, -2048, WO'(-16775168)};
        vt[3] = '{3, 8191, 2047, WO'(16766977)};
        vt[4] = '{1, -1, -1, WO'(1)};
        vt[5] = '{0, 0, -2048, WO'(0)};
        vt[6] = '{3, -8192, 2047, WO'(-16769024)};
        vt[7] = '{2, 1234, -567, WO'(-699678)};

        stepn     = 0;
        ap_rst_n  = 1'b1;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        res_ready = 1'b1;
        model_reset();
        #1 ap_rst_n = 1'b0;
        req_valid = '1;
        repeat (2) @(negedge ap_clk);
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_id", 64'(res_id), 64'(0));
        chk("rst_res_dout", 64'(res_dout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // single transactions: grant, then result exactly LAT cycles later
        foreach (vt[v]) begin
            set_op(vt[v].id, vt[v].d0, vt[v].d1);
            req_valid = N'(1) << vt[v].id;
            got = 0;
            for (int w = 0; w < 10 && got == 0; w++) begin
                step();
                if (obs_rdy[vt[v].id]) got = 1;
            end
            chk("vec_grant", 64'(got), 64'(1));
            req_valid = '0;
            seen = 0;
            lat  = 0;
            for (int w = 0; w < 10 && seen == 0; w++) begin
                step();
                lat++;
                if (obs_vld) seen = 1;
            end
            chk("vec_latency", 64'(lat), 64'(LAT));
            chk("vec_id", 64'(obs_id), 64'(vt[v].id));
            chk("vec_dout", 64'(obs_dout), 64'(vt[v].exp));
        end

        // reset with two products in flight
        set_op(1, 7, 9);
        req_valid = 4'b0010;
        step();
        step();
        #2 ap_rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", 64'(res_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        model_reset();
        req_valid = '0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (3) step();
        chk("midrst_no_stale", 64'(con_cnt), 64'(0));

        // all requesters valid: strict rotation from req 0, no gaps
        glog.delete();
        rlog.delete();
        rstep.delete();
        for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
        req_valid = '1;
        repeat (8) step();
        req_valid = '0;
        repeat (LAT + 1) step();
        chk("rot_count", 64'(glog.size()), 64'(8));
        chk("rot_res_count", 64'(rlog.size()), 64'(8));
        for (int k = 0; k < 8 && k < glog.size() && k < rlog.size(); k++) begin
            chk("rot_grant", 64'(glog[k]), 64'(k % N));
            chk("rot_result", 64'(rlog[k]), 64'(10 * (k % N + 1)));
            chk("rot_no_gap", 64'(rstep[k] - rstep[0]), 64'(k));
        end

        // backpressure: 3-cycle stall mid-stream from req 0
        rlog.delete();
        opn = 0;
        req_valid = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            set_op(0, 100 + opn, -3);
            res_ready = (c >= 4 && c < 7) ? 1'b0 : 1'b1;
            step();
            if (c >= 4 && c < 7) chk("stall_no_grant", 64'(obs_rdy), 64'(0));
            if (obs_rdy[0]) opn++;
        end
        res_ready = 1'b1;
        req_valid = '0;
        repeat (LAT + 2) step();
        chk("bp_count", 64'(rlog.size()), 64'(opn));
        for (int k = 0; k < rlog.size(); k++) begin
            chk("bp_order", 64'(rlog[k]), 64'(-3 * (100 + k)));
        end

        // fairness: req 3 joins a continuous req 0 stream
        glog.delete();
        set_op(0, 2, 2);
        set_op(3, 3, 3);
        req_valid = 4'b0001;
        repeat (5) step();
        req_valid = 4'b1001;
        repeat (10) step();
        req_valid = '0;
        repeat (LAT + 1) step();
        first3 = -1;
        for (int k = 0; k < glog.size(); k++) if (first3 < 0 && glog[k] == 3) first3 = k;
        chk("fair_first3_seen", 64'(first3 >= 0), 64'(1));
        chk("fair_first3_soon", 64'(first3 >= 5 && first3 <= 8), 64'(1));
        alt_ok = 1'b1;
        for (int k = 5; k + 1 < glog.size(); k++) begin
            if (glog[k] == glog[k+1] || (glog[k] != 0 && glog[k] != 3)) alt_ok = 1'b0;
        end
        chk("fair_alternate", 64'(alt_ok), 64'(1));

        // random traffic with random downstream stalls
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) set_op(i, int'($urandom), int'($urandom));
            req_valid = N'($urandom);
            res_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (LAT + 2) step();
        chk("rand_drain", 64'(con_cnt), 64'(acc_cnt));
        chk("rand_idle", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
